// File: rtl/led_pattern_seq_if.sv
// Control and LED bus for led_pattern_seq.
//   tick_in : slow divider toggle, asynchronous to clk
//   run     : 1 enables the sequence, 0 forces the LEDs off
//   mode    : 0 SHIFT, 1 BOUNCE, 2 BLINK, 3 COUNT
//   leds    : registered LED pattern
//   step    : one-cycle pulse, high in the cycle leds holds a new step value
//   wrap    : one-cycle pulse with step when the pattern completes a period
interface led_pattern_seq_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             tick_in;
    logic             run;
    logic [1:0]       mode;
    logic [WIDTH-1:0] leds;
    logic             step;
    logic             wrap;

    // Controller side: drives the controls and observes the LED bank.
    modport master (
        output tick_in,
        output run,
        output mode,
        input  leds,
        input  step,
        input  wrap
    );

    // Sequencer side.
    modport slave (
        input  tick_in,
        input  run,
        input  mode,
        output leds,
        output step,
        output wrap
    );
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer driven by the slow clock-divider toggle.
// Each synchronised edge of tick_in is one step; on every step the pattern advances
// in SHIFT, BOUNCE, BLINK or COUNT mode.
//   clk   : system clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : led_pattern_seq_if slave (tick_in, run, mode in; leds, step, wrap out)
module led_pattern_seq #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    led_pattern_seq_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    localparam logic [1:0] ModeShift  = 2'd0;
    localparam logic [1:0] ModeBounce = 2'd1;
    localparam logic [1:0] ModeBlink  = 2'd2;
    localparam logic [1:0] ModeCount  = 2'd3;

    localparam logic DirLeft  = 1'b0;
    localparam logic DirRight = 1'b1;

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e                 r_state, w_state_d;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_edge;
    logic [1:0]             r_mode_q, w_mode_q_d;
    logic                   r_dir, w_dir_d;
    logic [WIDTH-1:0]       r_leds, w_leds_d;
    logic                   r_step, w_step_d;
    logic                   r_wrap, w_wrap_d;

    // Synchroniser plus previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.tick_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = (EDGE_MODE == 1) ? (r_sync[SYNC_STAGES-1] & ~r_prev)
                                     : (r_sync[SYNC_STAGES-1] ^ r_prev);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_mode_q <= 2'd0;
            r_dir    <= DirLeft;
            r_leds   <= '0;
            r_step   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_mode_q <= w_mode_q_d;
            r_dir    <= w_dir_d;
            r_leds   <= w_leds_d;
            r_step   <= w_step_d;
            r_wrap   <= w_wrap_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (bus.run) w_state_d = StLoad;
            StLoad:  w_state_d = StRun;
            StRun: begin
                if (!bus.run) begin
                    w_state_d = StIdle;
                end else if (bus.mode != r_mode_q) begin
                    w_state_d = StLoad;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Pattern datapath. run/mode checks in RUN take priority, so a same-cycle edge is dropped.
    always_comb begin
        w_leds_d   = r_leds;
        w_dir_d    = r_dir;
        w_mode_q_d = r_mode_q;
        w_step_d   = 1'b0;
        w_wrap_d   = 1'b0;
        unique case (r_state)
            StIdle: w_leds_d = '0;
            StLoad: begin
                w_mode_q_d = bus.mode;
                w_dir_d    = DirLeft;
                unique case (bus.mode)
                    ModeShift:  w_leds_d = One;
                    ModeBounce: w_leds_d = One;
                    ModeBlink:  w_leds_d = '1;
                    ModeCount:  w_leds_d = '0;
                    default:    w_leds_d = '0;
                endcase
            end
            StRun: begin
                if (!bus.run) begin
                    w_leds_d = '0;
                end else if ((bus.mode == r_mode_q) && w_edge) begin
                    w_step_d = 1'b1;
                    unique case (r_mode_q)
                        ModeShift: begin
                            w_leds_d = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
                            w_wrap_d = r_leds[WIDTH-1];
                        end
                        ModeBounce: begin
                            if (r_dir == DirLeft) begin
                                w_leds_d = {r_leds[WIDTH-2:0], 1'b0};
                                // Turn around on the step that lands on the top bit.
                                if (r_leds[WIDTH-2]) w_dir_d = DirRight;
                            end else begin
                                w_leds_d = {1'b0, r_leds[WIDTH-1:1]};
                                if (r_leds[1]) begin
                                    w_dir_d  = DirLeft;
                                    w_wrap_d = 1'b1;
                                end
                            end
                        end
                        ModeBlink: begin
                            w_leds_d = ~r_leds;
                            w_wrap_d = (r_leds == '0);
                        end
                        ModeCount: begin
                            w_leds_d = r_leds + One;
                            w_wrap_d = &r_leds;
                        end
                        default: w_leds_d = r_leds;
                    endcase
                end
            end
            default: w_leds_d = '0;
        endcase
    end

    assign bus.leds = r_leds;
    assign bus.step = r_step;
    assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_seq.sv
module tb_led_pattern_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    led_pattern_seq_if #(.WIDTH(8)) u_if0 ();
    led_pattern_seq_if #(.WIDTH(8)) u_if1 ();

    // Second instance (rising edges only) shares the same controls.
    assign u_if1.tick_in = u_if0.tick_in;
    assign u_if1.run     = u_if0.run;
    assign u_if1.mode    = u_if0.mode;

    led_pattern_seq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if0)
    );

    led_pattern_seq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wraps_seen;
    int steps_seen;

    // Reference model: phase 0 idle, 1 load, 2 run; pattern is a function of step count.
    logic [1:0] m_sync;
    logic       m_prev;
    int         m_phase;
    int         m_mode_q;
    int         m_n;
    logic [7:0] m_leds;
    logic       m_step;
    logic       m_wrap;

    function automatic logic [7:0] pat(input int md, input int n);
        logic [7:0] one;
        int p;
        int pos;
        one = 8'h01;
        case (md)
            0: return one << (n % 8);
            1: begin
                p   = n % 14;
                pos = (p < 8) ? p : 14 - p;
                return one << pos;
            end
            2: return ((n % 2) == 0) ? 8'hFF : 8'h00;
            default: return 8'(n % 256);
        endcase
    endfunction

    function automatic int period(input int md);
        case (md)
            0: return 8;
            1: return 14;
            2: return 2;
            default: return 256;
        endcase
    endfunction

    task automatic model_clear();
        m_sync   = 2'b00;
        m_prev   = 1'b0;
        m_phase  = 0;
        m_mode_q = 0;
        m_n      = 0;
        m_leds   = 8'h00;
        m_step   = 1'b0;
        m_wrap   = 1'b0;
    endtask

    task automatic model_clock();
        logic edge_v;
        logic ns;
        logic nw;
        edge_v = m_sync[1] ^ m_prev;
        ns = 1'b0;
        nw = 1'b0;
        case (m_phase)
            0: begin
                m_leds = 8'h00;
                if (u_if0.run) m_phase = 1;
            end
            1: begin
                m_mode_q = int'(u_if0.mode);
                m_n      = 0;
                m_leds   = pat(m_mode_q, 0);
                m_phase  = 2;
            end
            default: begin
                if (!u_if0.run) begin
                    m_phase = 0;
                    m_leds  = 8'h00;
                end else if (int'(u_if0.mode) != m_mode_q) begin
                    m_phase = 1;
                end else if (edge_v) begin
                    m_n    = m_n + 1;
                    m_leds = pat(m_mode_q, m_n);
                    ns     = 1'b1;
                    nw     = ((m_n % period(m_mode_q)) == 0);
                end
            end
        endcase
        m_step = ns;
        m_wrap = nw;
        m_prev = m_sync[1];
        m_sync = {m_sync[0], u_if0.tick_in};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance the model with the inputs the DUT will see, then compare at negedge.
    task automatic cycle();
        model_clock();
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (u_if0.leds !== m_leds || u_if0.step !== m_step || u_if0.wrap !== m_wrap) begin
            n_fail++;
            $display("FAIL model t=%0t leds=%h step=%b wrap=%b expected leds=%h step=%b wrap=%b",
                     $time, u_if0.leds, u_if0.step, u_if0.wrap, m_leds, m_step, m_wrap);
        end
        if (u_if0.wrap === 1'b1) wraps_seen++;
        if (u_if0.step === 1'b1) steps_seen++;
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_leds", 32'(u_if0.leds), 32'h00);
        check("reset_step", 32'(u_if0.step), 32'h0);
        check("reset_wrap", 32'(u_if0.wrap), 32'h0);
        model_clear();
        u_if0.run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic toggle_spaced(input int count);
        for (int t = 0; t < count; t++) begin
            u_if0.tick_in = ~u_if0.tick_in;
            repeat ($urandom_range(1, 4)) cycle();
        end
        repeat (4) cycle();
    endtask

    // Reset, release idle, then enter RUN in the given mode.
    task automatic start_mode(input logic [1:0] md);
        u_if0.tick_in = 1'b0;
        do_reset();
        u_if0.mode = md;
        repeat (2) cycle();
        check("idle_leds", 32'(u_if0.leds), 32'h00);
        u_if0.run = 1'b1;
        repeat (3) cycle();
    endtask

    typedef struct {
        logic [1:0] mode;
        int         toggles;
        logic [7:0] exp_leds;
        int         exp_wraps;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b1;
        u_if0.tick_in = 1'b0;
        u_if0.run     = 1'b0;
        u_if0.mode    = 2'd0;
        model_clear();

        vecs[0]  = '{2'd0,   8, 8'h01, 1};
        vecs[1]  = '{2'd0,   3, 8'h08, 0};
        vecs[2]  = '{2'd1,   7, 8'h80, 0};
        vecs[3]  = '{2'd1,  14, 8'h01, 1};
        vecs[4]  = '{2'd1,   9, 8'h20, 0};
        vecs[5]  = '{2'd1,  28, 8'h01, 2};
        vecs[6]  = '{2'd2,   1, 8'h00, 0};
        vecs[7]  = '{2'd2,   2, 8'hFF, 1};
        vecs[8]  = '{2'd3, 255, 8'hFF, 0};
        vecs[9]  = '{2'd3, 256, 8'h00, 1};
        vecs[10] = '{2'd3,   5, 8'h05, 0};

        for (int v = 0; v < 11; v++) begin
            start_mode(vecs[v].mode);
            wraps_seen = 0;
            steps_seen = 0;
            toggle_spaced(vecs[v].toggles);
            check($sformatf("vec%0d_leds", v), 32'(u_if0.leds), 32'(vecs[v].exp_leds));
            check($sformatf("vec%0d_wraps", v), 32'(wraps_seen), 32'(vecs[v].exp_wraps));
            check($sformatf("vec%0d_steps", v), 32'(steps_seen), 32'(vecs[v].toggles));
        end

        // Latency: toggle captured at edge k shows on leds after edge k+2.
        start_mode(2'd0);
        check("lat_seed", 32'(u_if0.leds), 32'h01);
        u_if0.tick_in = 1'b1;
        cycle();
        check("lat_k0", 32'(u_if0.leds), 32'h01);
        cycle();
        check("lat_k1", 32'(u_if0.leds), 32'h01);
        check("lat_k1_step", 32'(u_if0.step), 32'h0);
        cycle();
        check("lat_k2", 32'(u_if0.leds), 32'h02);
        check("lat_k2_step", 32'(u_if0.step), 32'h1);
        check("lat_rise_edge1", 32'(u_if1.leds), 32'h02);
        cycle();
        check("lat_k3_step", 32'(u_if0.step), 32'h0);
        u_if0.tick_in = 1'b0;
        repeat (4) cycle();
        check("fall_edge0", 32'(u_if0.leds), 32'h04);
        check("fall_edge1", 32'(u_if1.leds), 32'h02);

        // Mode change coincident with an edge: edge dropped, new seed loaded.
        u_if0.tick_in = 1'b1;
        cycle();
        cycle();
        u_if0.mode = 2'd2;
        cycle();
        check("mchg_nostep", 32'(u_if0.step), 32'h0);
        check("mchg_hold", 32'(u_if0.leds), 32'h04);
        cycle();
        check("mchg_seed", 32'(u_if0.leds), 32'hFF);
        check("mchg_nostep2", 32'(u_if0.step), 32'h0);
        repeat (3) cycle();
        check("mchg_dropped", 32'(u_if0.leds), 32'hFF);
        toggle_spaced(1);
        check("blink_off", 32'(u_if0.leds), 32'h00);
        toggle_spaced(1);
        check("blink_on", 32'(u_if0.leds), 32'hFF);
        u_if0.run = 1'b0;
        cycle();
        check("run_off", 32'(u_if0.leds), 32'h00);

        // Mode flips and flips back before LOAD: still reloads once.
        u_if0.mode = 2'd3;
        u_if0.run  = 1'b1;
        repeat (3) cycle();
        toggle_spaced(3);
        check("flip_pre", 32'(u_if0.leds), 32'h03);
        u_if0.mode = 2'd1;
        cycle();
        u_if0.mode = 2'd3;
        cycle();
        check("flip_reload", 32'(u_if0.leds), 32'h00);
        toggle_spaced(1);
        check("flip_after", 32'(u_if0.leds), 32'h01);

        // Randomised run against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) u_if0.tick_in = ~u_if0.tick_in;
            if ($urandom_range(0, 39) == 0) u_if0.mode = 2'($urandom_range(0, 3));
            u_if0.run = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                u_if0.run = 1'b1;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
